// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer receive-path stage.
package nibble_packer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int unsigned DEF_NIB_NUM = 4;
    localparam int unsigned DEF_TIMEOUT = 5_000_000;

    // Timer width for a given timeout, never narrower than one bit
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    localparam int unsigned DEF_TIMER_W = timer_width(DEF_TIMEOUT);

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble input / packed word output bundle of the nibble packer.
interface nibble_packer_if #(
    parameter int unsigned NIB_NUM = nibble_packer_pkg::DEF_NIB_NUM
);
    logic [3:0]           din;
    logic                 din_vld;
    logic [4*NIB_NUM-1:0] dout;
    logic                 dout_vld;
    logic                 timeout_err;

    modport master (output din, output din_vld,
                    input  dout, input dout_vld, input timeout_err);
    modport slave  (input  din, input din_vld,
                    output dout, output dout_vld, output timeout_err);
endinterface

// File: rtl/nibble_packer_idle_timer.sv
// Idle-cycle timer: counts enabled cycles, flags the last one before timeout.
module idle_timer #(
    parameter int unsigned TIMEOUT = nibble_packer_pkg::DEF_TIMEOUT,
    parameter int unsigned W       = nibble_packer_pkg::timer_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Clear has priority, so a qualifying event on the final cycle suppresses expiry
    assign expire_c = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || expire_c) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + W'(1);
        end
    end
endmodule

// File: rtl/nibble_packer.sv
// Packs MSB-first hex nibbles into NIB_NUM-nibble words; drops stalled partial words.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned NIB_NUM = DEF_NIB_NUM,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    nibble_packer_if.slave  bus
);
    localparam int unsigned WORD_W   = 4 * NIB_NUM;
    localparam int unsigned CNT_W    = $clog2(NIB_NUM) + 1;
    localparam int unsigned LAST_CNT = NIB_NUM - 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   sh_in_c;
    logic                tmr_clear_c;
    logic                tmr_en_c;
    logic                expire_c;

    assign sh_in_c     = (sh_q << 4) | WORD_W'(bus.din);
    assign tmr_en_c    = (state_q == COLLECT);
    assign tmr_clear_c = (state_q == IDLE) || bus.din_vld;

    idle_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (timer_width(TIMEOUT))
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear_c),
        .enable   (tmr_en_c),
        .expire_c (expire_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.din_vld) begin
                    if (NIB_NUM == 1) begin
                        dout_d     = sh_in_c;
                        dout_vld_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        cnt_d   = CNT_W'(1);
                        sh_d    = sh_in_c;
                    end
                end
            end
            COLLECT: begin
                if (bus.din_vld) begin
                    if (cnt_q == CNT_W'(LAST_CNT)) begin
                        dout_d     = sh_in_c;
                        dout_vld_d = 1'b1;
                        cnt_d      = '0;
                        sh_d       = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        sh_d  = sh_in_c;
                    end
                end else if (expire_c) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            err_q      <= err_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_vld    = dout_vld_q;
    assign bus.timeout_err = err_q;
endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter NIB_NUM, default 4: nibbles per output word.
REQ-002 SHALL have parameter TIMEOUT, default 5_000_000: idle cycles between nibbles before a partial word is discarded (100 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port din, input, 4: hex nibble from the ASCII-to-hex stage.
REQ-006 SHALL have port din_vld, input, 1: din valid, one-cycle qualifier, no backpressure.
REQ-007 SHALL have port dout, output, 4*NIB_NUM: assembled word.
REQ-008 SHALL have port dout_vld, output, 1: one-cycle pulse, dout valid.
REQ-009 SHALL have port timeout_err, output, 1: one-cycle pulse, partial word discarded.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no nibbles held) and COLLECT (1..NIB_NUM-1 nibbles held).
REQ-011 SHALL shift each accepted nibble in MSB-first: the first nibble of a word lands in dout[4*NIB_NUM-1 -: 4], the last in dout[3:0].
REQ-012 SHALL keep a nibble counter (width ceil(log2(NIB_NUM))+1) counting 0..NIB_NUM-1 and wrapping to 0 on the final nibble.
REQ-013 IDLE -> COLLECT on din_vld when NIB_NUM>1; counter becomes 1 and the timer clears.
REQ-014 In COLLECT, din_vld on the NIB_NUM-th nibble SHALL register the complete word to dout, pulse dout_vld the next cycle (1-cycle latency from the last din_vld), clear the counter and return to IDLE.
REQ-015 Back-to-back words SHALL be supported: din_vld on every cycle yields one dout_vld every NIB_NUM cycles with no lost nibble.
REQ-016 dout SHALL hold its last completed word until the next completion; it SHALL NOT change on partial accumulation (separate shift register from the output register).
REQ-017 In COLLECT, a timer SHALL count cycles without din_vld; when it reaches TIMEOUT-1, the FSM SHALL discard the partial word, clear the counter, pulse timeout_err the next cycle and return to IDLE.
REQ-018 Timer SHALL be held at 0 in IDLE and cleared on every accepted nibble.
REQ-019 If din_vld coincides with the timer reaching TIMEOUT-1, the nibble SHALL win: it is accepted, the timer clears, and timeout_err is not raised.
REQ-020 dout_vld and timeout_err SHALL never be asserted in the same cycle.
REQ-021 din SHALL be ignored when din_vld=0.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE; counter, timer and shift register = 0; dout=0; dout_vld=0; timeout_err=0.
REQ-023 Reset mid-word SHALL discard all held nibbles; the first din_vld after release starts a new word.
REQ-024 No output pulse SHALL be generated by reset assertion or release.

Structure
REQ-025 FSM state encodings and the default TIMEOUT/NIB_NUM constants SHALL live in the project shared package; the timer width SHALL be derived there with $clog2.
REQ-026 The timeout counter SHALL be a sub-module, idle_timer (clear, enable, expire pulse), reusable by other receive-path stages.
REQ-027 The whole block SHALL be single-clock with no combinational path from din to any output.

Verification (TIMEOUT=16, NIB_NUM=4 unless stated)
REQ-028 Nibbles 0x1,0x2,0x3,0x4 with gaps of 3 cycles -> dout=0x1234, dout_vld one pulse 1 cycle after the 4th din_vld, timeout_err=0.
REQ-029 8 consecutive cycles of din_vld carrying 0xA..0xF,0x0,0x1 -> two dout_vld pulses 4 cycles apart, dout=0xABCD then 0xEF01.
REQ-030 0x5,0x6 then 16 idle cycles -> timeout_err one pulse, no dout_vld, dout unchanged; then 0x7,0x8,0x9,0xA -> dout=0x789A.
REQ-031 Nibble arriving exactly on the cycle the timer reaches 15 -> accepted, no timeout_err, word completes normally.
REQ-032 rst_n pulsed low after 3 nibbles (0xC,0xD,0xE) -> all outputs 0 immediately; next 0x1,0x2,0x3,0x4 -> dout=0x1234.
REQ-033 din toggling with din_vld=0 for 100 cycles in IDLE -> no output pulses, dout stable.
